// File: rtl/pfmonitor_tbl.sv
// Prefetch delta monitor: direct-mapped table of per-signature (delta, weight)
// slots, looked up at decode (result queued to the core) and trained at retire.

// One delta slot's training rule: reinforce a matching delta, decay a mismatch,
// and replace the delta once its confidence has run out.
module pfmonitor_slot #(
  parameter int DELTA_W  = 8,
  parameter int WEIGHT_W = 3
) (
  input  logic                hit,
  input  logic                dvalid,
  input  logic [DELTA_W-1:0]  old_delta,
  input  logic [DELTA_W-1:0]  obs_delta,
  input  logic [WEIGHT_W-1:0] old_w,
  output logic [DELTA_W-1:0]  new_delta,
  output logic [WEIGHT_W-1:0] new_w
);
  localparam logic [WEIGHT_W-1:0] WMAX = '1;
  localparam logic [WEIGHT_W-1:0] WONE = WEIGHT_W'(1);

  // Next slot contents for an accepted retire; allocation wipes unobserved slots.
  always_comb begin
    new_delta = old_delta;
    new_w     = old_w;
    if (!hit) begin
      new_delta = dvalid ? obs_delta : '0;
      new_w     = dvalid ? WONE : '0;
    end else if (dvalid) begin
      if (obs_delta == old_delta) begin
        if (old_w != WMAX) new_w = old_w + WONE;
      end else if (old_w > WONE) begin
        new_w = old_w - WONE;
      end else begin
        new_delta = obs_delta;
        new_w     = WONE;
      end
    end
  end
endmodule

module pfmonitor_tbl #(
  parameter int PCSIGN_W   = 12,
  parameter int ROBID_W    = 6,
  parameter int DELTA_W    = 8,
  parameter int WEIGHT_W   = 3,
  parameter int NDELTA     = 4,
  parameter int ENTRIES    = 16,
  parameter int PRED_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          dec_valid,
  output logic                          dec_retry,
  input  logic [PCSIGN_W-1:0]           dec_pcsign,
  input  logic [ROBID_W-1:0]            dec_rid,
  input  logic                          ret_valid,
  output logic                          ret_retry,
  input  logic [PCSIGN_W-1:0]           ret_pcsign,
  input  logic [NDELTA-1:0]             ret_dvalid,
  input  logic [NDELTA*DELTA_W-1:0]     ret_delta,
  input  logic                          flush,
  output logic                          pred_valid,
  input  logic                          pred_retry,
  output logic [$clog2(ENTRIES)-1:0]    pred_pfentry,
  output logic                          pred_hit,
  output logic [NDELTA*ROBID_W-1:0]     pred_rid,
  output logic [NDELTA*DELTA_W-1:0]     pred_delta,
  output logic [NDELTA*WEIGHT_W-1:0]    pred_w,
  output logic [15:0]                   stat_lookups,
  output logic [15:0]                   stat_hits
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PCSIGN_W - IDX_W;
  localparam int PTR_W = (PRED_DEPTH > 1) ? $clog2(PRED_DEPTH) : 1;
  localparam int CNT_W = $clog2(PRED_DEPTH + 1);

  typedef logic [NDELTA-1:0][DELTA_W-1:0]  delta_vec_t;
  typedef logic [NDELTA-1:0][WEIGHT_W-1:0] w_vec_t;
  typedef logic [NDELTA-1:0][ROBID_W-1:0]  rid_vec_t;

  typedef struct packed {
    logic [IDX_W-1:0] pfentry;
    logic             hit;
    rid_vec_t         rid;
    delta_vec_t       delta;
    w_vec_t           w;
  } pred_t;

  // Table state
  logic [ENTRIES-1:0] tbl_vld;
  logic [TAG_W-1:0]   tbl_tag   [ENTRIES];
  delta_vec_t         tbl_delta [ENTRIES];
  w_vec_t             tbl_w     [ENTRIES];

  // Prediction FIFO state
  pred_t              fifo_q [PRED_DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count;

  // Decode side
  logic [IDX_W-1:0]   dec_idx;
  logic [TAG_W-1:0]   dec_tag;
  logic               push, pop;
  pred_t              push_data;

  // Retire side
  logic [IDX_W-1:0]   ret_idx;
  logic [TAG_W-1:0]   ret_tag;
  logic               ret_fire, ret_hit;
  delta_vec_t         obs_delta, new_delta;
  w_vec_t             new_w;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(PRED_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // dec_retry depends only on the registered fill level, never on pred_retry.
  assign dec_retry = (count == CNT_W'(PRED_DEPTH));
  assign ret_retry = flush;
  assign push      = dec_valid && !dec_retry;
  assign pred_valid = (count != '0);
  assign pop       = pred_valid && !pred_retry;
  assign ret_fire  = ret_valid && !ret_retry;

  assign dec_idx = dec_pcsign[IDX_W-1:0];
  assign dec_tag = dec_pcsign[PCSIGN_W-1:IDX_W];
  assign ret_idx = ret_pcsign[IDX_W-1:0];
  assign ret_tag = ret_pcsign[PCSIGN_W-1:IDX_W];
  assign ret_hit = tbl_vld[ret_idx] && (tbl_tag[ret_idx] == ret_tag);
  assign obs_delta = ret_delta;

  // Combinational lookup of the pre-write table; misses report all-zero slots.
  always_comb begin
    push_data         = '0;
    push_data.pfentry = dec_idx;
    push_data.hit     = tbl_vld[dec_idx] && (tbl_tag[dec_idx] == dec_tag);
    for (int k = 0; k < NDELTA; k++)
      push_data.rid[k] = dec_rid + ROBID_W'(k);
    if (push_data.hit) begin
      push_data.delta = tbl_delta[dec_idx];
      push_data.w     = tbl_w[dec_idx];
    end
  end

  for (genvar k = 0; k < NDELTA; k++) begin : g_slot
    pfmonitor_slot #(.DELTA_W(DELTA_W), .WEIGHT_W(WEIGHT_W)) u_slot (
      .hit       (ret_hit),
      .dvalid    (ret_dvalid[k]),
      .old_delta (tbl_delta[ret_idx][k]),
      .obs_delta (obs_delta[k]),
      .old_w     (tbl_w[ret_idx][k]),
      .new_delta (new_delta[k]),
      .new_w     (new_w[k])
    );
  end

  // Table update: flush clears valid bits and blocks retire in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tbl_vld <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_tag[i]   <= '0;
        tbl_delta[i] <= '0;
        tbl_w[i]     <= '0;
      end
    end else if (flush) begin
      tbl_vld <= '0;
    end else if (ret_fire) begin
      tbl_vld[ret_idx]   <= 1'b1;
      tbl_tag[ret_idx]   <= ret_tag;
      tbl_delta[ret_idx] <= new_delta;
      tbl_w[ret_idx]     <= new_w;
    end
  end

  // In-order prediction FIFO; storage is cleared so outputs read zero after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < PRED_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= push_data;
        wr_ptr         <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Saturating lookup/hit counters over accepted decodes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_lookups <= '0;
      stat_hits    <= '0;
    end else if (push) begin
      if (stat_lookups != 16'hFFFF) stat_lookups <= stat_lookups + 16'd1;
      if (push_data.hit && stat_hits != 16'hFFFF) stat_hits <= stat_hits + 16'd1;
    end
  end

  assign pred_pfentry = fifo_q[rd_ptr].pfentry;
  assign pred_hit     = fifo_q[rd_ptr].hit;
  assign pred_rid     = fifo_q[rd_ptr].rid;
  assign pred_delta   = fifo_q[rd_ptr].delta;
  assign pred_w       = fifo_q[rd_ptr].w;
endmodule

// File: tb/tb_pfmonitor_tbl.sv
// Scoreboard bench for pfmonitor_tbl: stimulus queues hand-computed predictions,
// a negedge monitor pops and compares every transferred prediction.
module tb_pfmonitor_tbl;
  logic        clk = 0, reset = 1;
  logic        dec_valid = 0, dec_retry;
  logic [11:0] dec_pcsign = '0;
  logic [5:0]  dec_rid = '0;
  logic        ret_valid = 0, ret_retry;
  logic [11:0] ret_pcsign = '0;
  logic [3:0]  ret_dvalid = '0;
  logic [31:0] ret_delta = '0;
  logic        flush = 0;
  logic        pred_valid, pred_retry = 0;
  logic [3:0]  pred_pfentry;
  logic        pred_hit;
  logic [23:0] pred_rid;
  logic [31:0] pred_delta;
  logic [11:0] pred_w;
  logic [15:0] stat_lookups, stat_hits;

  int checks = 0, errors = 0;

  typedef struct packed {
    logic [3:0]  idx;
    logic        hit;
    logic [23:0] rid;
    logic [31:0] delta;
    logic [11:0] w;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  pfmonitor_tbl dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_retry(dec_retry), .dec_pcsign(dec_pcsign), .dec_rid(dec_rid),
    .ret_valid(ret_valid), .ret_retry(ret_retry), .ret_pcsign(ret_pcsign),
    .ret_dvalid(ret_dvalid), .ret_delta(ret_delta), .flush(flush),
    .pred_valid(pred_valid), .pred_retry(pred_retry), .pred_pfentry(pred_pfentry),
    .pred_hit(pred_hit), .pred_rid(pred_rid), .pred_delta(pred_delta), .pred_w(pred_w),
    .stat_lookups(stat_lookups), .stat_hits(stat_hits)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [23:0] rids(input logic [5:0] base);
    logic [23:0] r;
    for (int k = 0; k < 4; k++) r[k*6 +: 6] = base + 6'(k);
    return r;
  endfunction

  // Monitor: every prediction transfer must match the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && pred_valid && !pred_retry) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL pred_unexpected: got idx %0h hit %0b, expected none", pred_pfentry, pred_hit);
      end else begin
        mon_e = sb.pop_front();
        check("pred", {pred_pfentry, pred_hit, pred_rid, pred_delta, pred_w}, mon_e);
      end
    end
  end

  task automatic decode(input logic [11:0] pc, input logic [5:0] rid, input logic hit,
                        input logic [31:0] d, input logic [11:0] w);
    int n = 0;
    dec_valid = 1; dec_pcsign = pc; dec_rid = rid;
    while (dec_retry && n < 50) begin @(posedge clk); #1; n++; end
    if (dec_retry) begin
      check("dec_timeout", 1, 0);
      dec_valid = 0;
      return;
    end
    sb.push_back({pc[3:0], hit, rids(rid), d, w});
    @(posedge clk); #1;
    dec_valid = 0;
  endtask

  task automatic retire(input logic [11:0] pc, input logic [3:0] dv, input logic [31:0] d);
    ret_valid = 1; ret_pcsign = pc; ret_dvalid = dv; ret_delta = d;
    @(posedge clk); #1;
    ret_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || pred_valid) && n < 50) begin @(posedge clk); #1; n++; end
    check("drain", {sb.size() != 0, pred_valid}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. reset values, first miss lookup
    repeat (2) @(posedge clk); #1;
    check("rst_pred_valid", pred_valid, 0);
    check("rst_dec_retry", dec_retry, 0);
    check("rst_stats", {stat_lookups, stat_hits}, 0);
    check("rst_pred", {pred_hit, pred_rid, pred_delta, pred_w}, 0);
    reset = 0;
    @(posedge clk); #1;
    decode(12'h0A3, 6'd5, 0, 32'h0, 12'h0);
    check("t1_lookups", stat_lookups, 1);
    check("t1_hits", stat_hits, 0);
    drain();

    // 2. allocate, then saturate both observed slots
    retire(12'h0A3, 4'b0011, {8'd9, 8'd9, 8'd2, 8'd5});
    decode(12'h0A3, 6'd62, 1, 32'h0000_0205, 12'h009);
    repeat (8) retire(12'h0A3, 4'b0011, {8'd9, 8'd9, 8'd2, 8'd5});
    decode(12'h0A3, 6'd0, 1, 32'h0000_0205, 12'h03F);
    check("t2_stats", {stat_lookups, stat_hits}, {16'd3, 16'd2});
    drain();

    // 3. backpressure: FIFO fills at 2, head held stable, drains in order
    pred_retry = 1;
    decode(12'h0A3, 6'd10, 1, 32'h0000_0205, 12'h03F);
    decode(12'h011, 6'd20, 0, 32'h0, 12'h0);
    check("t3_dec_retry", dec_retry, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_hold", {pred_valid, pred_pfentry, pred_hit, pred_rid, pred_delta},
            {1'b1, 4'h3, 1'b1, rids(6'd10), 32'h0000_0205});
    end
    fork
      decode(12'h1A3, 6'd30, 0, 32'h0, 12'h0);
      begin repeat (2) @(posedge clk); #1 pred_retry = 0; end
    join
    drain();
    check("t3_stats", {stat_lookups, stat_hits}, {16'd6, 16'd3});

    // 4. decay slot0 on mismatch; same-cycle decode sees pre-write contents
    ret_valid = 1; ret_pcsign = 12'h0A3; ret_dvalid = 4'b0001; ret_delta = 32'h0000_00FF;
    decode(12'h0A3, 6'd40, 1, 32'h0000_0205, 12'h03F);
    ret_valid = 0;
    decode(12'h0A3, 6'd41, 1, 32'h0000_0205, 12'h03E);
    repeat (5) retire(12'h0A3, 4'b0001, 32'h0000_00FF);
    retire(12'h0A3, 4'b0001, 32'h0000_00FF);
    decode(12'h0A3, 6'd42, 1, 32'h0000_02FF, 12'h039);
    drain();

    // 5. flush blocks retire, old table visible in flush cycle, then reallocation
    flush = 1; ret_valid = 1; ret_pcsign = 12'h0A3; ret_dvalid = 4'b0001; ret_delta = 32'h5;
    #1 check("t5_ret_retry", ret_retry, 1);
    decode(12'h0A3, 6'd50, 1, 32'h0000_02FF, 12'h039);
    flush = 0; ret_valid = 0;
    decode(12'h0A3, 6'd51, 0, 32'h0, 12'h0);
    retire(12'h1A3, 4'b0100, {8'd0, 8'd3, 8'd0, 8'd0});
    decode(12'h1A3, 6'd52, 1, 32'h0003_0000, 12'h040);
    decode(12'h0A3, 6'd53, 0, 32'h0, 12'h0);
    drain();
    check("t5_stats", {stat_lookups, stat_hits}, {16'd13, 16'd8});

    // 6. async reset with two predictions pending
    pred_retry = 1;
    decode(12'h0A3, 6'd1, 0, 32'h0, 12'h0);
    decode(12'h1A3, 6'd2, 1, 32'h0003_0000, 12'h040);
    check("t6_full", dec_retry, 1);
    @(negedge clk); #1 reset = 1;
    #1;
    check("t6_rst_valid", pred_valid, 0);
    check("t6_rst_stats", {stat_lookups, stat_hits}, 0);
    check("t6_rst_dec_retry", dec_retry, 0);
    sb.delete();
    pred_retry = 0;
    @(posedge clk); #1 reset = 0;
    @(posedge clk); #1;
    decode(12'h1A3, 6'd3, 0, 32'h0, 12'h0);
    check("t6_stats", {stat_lookups, stat_hits}, {16'd1, 16'd0});
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
